// File: rtl/bb_descrambler.sv
// Receive-side BB descrambler: strips the additive 1 + x^14 + x^15 PRBS bit by bit,
// reseeding on every accepted sof and tracking frame length to flag eof and framing errors.
module bb_descrambler #(
    parameter int          LEN_W    = 16,
    parameter logic [1:15] DEF_INIT = 15'b100101010000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:15]      initial_state,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             sof,
    input  logic             in_bit,
    input  logic             en,
    output logic             out_bit,
    output logic             descmb_en,
    output logic             eof,
    output logic             frame_err,
    output logic             drop_err
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state, state_n;
    logic [1:15]      lfsr, lfsr_n;
    logic [LEN_W-1:0] cnt, cnt_n;
    logic [LEN_W-1:0] len_q, len_n;
    logic [LEN_W-1:0] cnt_inc;
    logic             out_n, valid_n, eof_n, ferr_n, derr_n;
    logic             fb, seed_fb;

    assign fb      = lfsr[14] ^ lfsr[15];
    assign seed_fb = initial_state[14] ^ initial_state[15];
    assign cnt_inc = cnt + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lfsr      <= DEF_INIT;
            cnt       <= '0;
            len_q     <= '0;
            out_bit   <= 1'b0;
            descmb_en <= 1'b0;
            eof       <= 1'b0;
            frame_err <= 1'b0;
            drop_err  <= 1'b0;
        end else begin
            state     <= state_n;
            lfsr      <= lfsr_n;
            cnt       <= cnt_n;
            len_q     <= len_n;
            out_bit   <= out_n;
            descmb_en <= valid_n;
            eof       <= eof_n;
            frame_err <= ferr_n;
            drop_err  <= derr_n;
        end
    end

    // A sof always wins: in RUN it abandons the current frame (frame_err) and
    // the bit is then treated exactly like a sof seen in IDLE.
    always_comb begin
        state_n = state;
        lfsr_n  = lfsr;
        cnt_n   = cnt;
        len_n   = len_q;
        out_n   = 1'b0;
        valid_n = 1'b0;
        eof_n   = 1'b0;
        ferr_n  = 1'b0;
        derr_n  = 1'b0;
        if (en) begin
            if (sof) begin
                if (state == RUN) begin
                    ferr_n = 1'b1;
                end
                if (frame_len == '0) begin
                    ferr_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    out_n   = in_bit ^ seed_fb;
                    valid_n = 1'b1;
                    lfsr_n  = {seed_fb, initial_state[1:14]};
                    cnt_n   = {{(LEN_W-1){1'b0}}, 1'b1};
                    len_n   = frame_len;
                    if (frame_len == {{(LEN_W-1){1'b0}}, 1'b1}) begin
                        eof_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = RUN;
                    end
                end
            end else if (state == RUN) begin
                out_n   = in_bit ^ fb;
                valid_n = 1'b1;
                lfsr_n  = {fb, lfsr[1:14]};
                cnt_n   = cnt_inc;
                if (cnt_inc == len_q) begin
                    eof_n   = 1'b1;
                    state_n = IDLE;
                end
            end else begin
                derr_n = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bb_descrambler.sv
// Directed self-checking bench for bb_descrambler: known PRBS prefix, scrambler loopback,
// en gaps, sof truncation, dropped bits, zero/one-length frames and async reset.
module tb_bb_descrambler;

    localparam logic [1:15] DEF = 15'b100101010000000;

    logic        clk;
    logic        reset;
    logic [1:15] initial_state;
    logic [15:0] frame_len;
    logic        sof;
    logic        in_bit;
    logic        en;
    logic        out_bit;
    logic        descmb_en;
    logic        eof;
    logic        frame_err;
    logic        drop_err;

    int checks;
    int errors;

    logic [13:0] t1_exp;
    logic        payload [1000];

    bb_descrambler dut (
        .clk           (clk),
        .reset         (reset),
        .initial_state (initial_state),
        .frame_len     (frame_len),
        .sof           (sof),
        .in_bit        (in_bit),
        .en            (en),
        .out_bit       (out_bit),
        .descmb_en     (descmb_en),
        .eof           (eof),
        .frame_err     (frame_err),
        .drop_err      (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; outputs for that bit are valid #1 after the next rise.
    task automatic applyStimulus(input logic e, input logic s, input logic b);
        @(negedge clk);
        en     = e;
        sof    = s;
        in_bit = b;
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_out"}, {31'd0, out_bit}, 32'd0);
        checkOutput({tag, "_den"}, {31'd0, descmb_en}, 32'd0);
        checkOutput({tag, "_eof"}, {31'd0, eof}, 32'd0);
        checkOutput({tag, "_ferr"}, {31'd0, frame_err}, 32'd0);
        checkOutput({tag, "_derr"}, {31'd0, drop_err}, 32'd0);
    endtask

    // Fourteen zero bits seeded with DEF; frame_len/initial_state are scrambled after the sof bit.
    task automatic checkT1Frame(input string tag, input bit gaps, input bit first_err);
        for (int i = 0; i < 14; i++) begin
            if (i == 0) begin
                frame_len     = 16'd14;
                initial_state = DEF;
            end else begin
                frame_len     = 16'd99;
                initial_state = 15'h1234;
            end
            applyStimulus(1'b1, (i == 0), 1'b0);
            checkOutput($sformatf("%s_out%0d", tag, i), {31'd0, out_bit}, {31'd0, t1_exp[13-i]});
            checkOutput($sformatf("%s_den%0d", tag, i), {31'd0, descmb_en}, 32'd1);
            checkOutput($sformatf("%s_eof%0d", tag, i), {31'd0, eof}, (i == 13) ? 32'd1 : 32'd0);
            checkOutput($sformatf("%s_ferr%0d", tag, i), {31'd0, frame_err},
                        (i == 0 && first_err) ? 32'd1 : 32'd0);
            if (gaps && i < 13) begin
                applyStimulus(1'b0, 1'b0, 1'b1);
                checkOutput($sformatf("%s_gapden%0d", tag, i), {31'd0, descmb_en}, 32'd0);
                checkOutput($sformatf("%s_gapeof%0d", tag, i), {31'd0, eof}, 32'd0);
            end
        end
    endtask

    initial begin
        logic [1:15] m;
        logic        fb;
        int          nbad;
        int          nen;
        int          neof;

        checks        = 0;
        errors        = 0;
        t1_exp        = 14'b00000011111101;
        reset         = 1'b1;
        en            = 1'b0;
        sof           = 1'b0;
        in_bit        = 1'b0;
        frame_len     = 16'd0;
        initial_state = DEF;

        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] T1 known PRBS prefix");
        checkT1Frame("t1", 1'b0, 1'b0);

        $display("[TB] T2 scrambler loopback");
        m    = DEF;
        nbad = 0;
        nen  = 0;
        neof = 0;
        frame_len     = 16'd1000;
        initial_state = DEF;
        for (int i = 0; i < 1000; i++) payload[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 1000; i++) begin
            fb = m[14] ^ m[15];
            m  = {fb, m[1:14]};
            applyStimulus(1'b1, (i == 0), payload[i] ^ fb);
            if (descmb_en) nen++;
            if (eof) neof++;
            if (out_bit !== payload[i]) nbad++;
            if (i == 999) checkOutput("t2_last_eof", {31'd0, eof}, 32'd1);
        end
        checkOutput("t2_bad_bits", nbad, 32'd0);
        checkOutput("t2_den_count", nen, 32'd1000);
        checkOutput("t2_eof_count", neof, 32'd1);

        $display("[TB] T3 en gaps");
        checkT1Frame("t3", 1'b1, 1'b0);

        $display("[TB] T4 truncation by new sof");
        frame_len     = 16'd20;
        initial_state = DEF;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, (i == 0), 1'b0);
            checkOutput($sformatf("t4a_out%0d", i), {31'd0, out_bit}, {31'd0, t1_exp[13-i]});
            checkOutput($sformatf("t4a_eof%0d", i), {31'd0, eof}, 32'd0);
            checkOutput($sformatf("t4a_ferr%0d", i), {31'd0, frame_err}, 32'd0);
        end
        checkT1Frame("t4b", 1'b0, 1'b1);

        $display("[TB] T5 dropped bits and zero/one length frames");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            checkOutput($sformatf("t5_derr%0d", i), {31'd0, drop_err}, 32'd1);
            checkOutput($sformatf("t5_den%0d", i), {31'd0, descmb_en}, 32'd0);
        end
        frame_len = 16'd0;
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("t5_len0_ferr", {31'd0, frame_err}, 32'd1);
        checkOutput("t5_len0_den", {31'd0, descmb_en}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t5_len0_idle", {31'd0, drop_err}, 32'd1);
        frame_len     = 16'd1;
        initial_state = 15'b000000000000001;
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t5_len1_out", {31'd0, out_bit}, 32'd1);
        checkOutput("t5_len1_eof", {31'd0, eof}, 32'd1);
        checkOutput("t5_len1_den", {31'd0, descmb_en}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t5_len1_idle", {31'd0, drop_err}, 32'd1);
        checkOutput("t5_len1_idle_den", {31'd0, descmb_en}, 32'd0);

        $display("[TB] T6 reset mid-frame");
        frame_len     = 16'd20;
        initial_state = DEF;
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, (i == 0), 1'b1);
        checkOutput("t6_pre_den", {31'd0, descmb_en}, 32'd1);
        #1;
        en    = 1'b0;
        sof   = 1'b0;
        reset = 1'b1;
        #1;
        checkAllZero("t6_async");
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("t6_held");
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t6_idle_derr", {31'd0, drop_err}, 32'd1);
        checkT1Frame("t6", 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
